pipe_delay_line: RTL and testbench



---
 rtl/pipe_delay_line_pkg.sv | 13 +
 rtl/pipe_delay_line_stage.sv | 54 +++++
 rtl/pipe_delay_line.sv | 96 +++++++++
 tb/tb_pipe_delay_line.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_delay_line_pkg.sv
// Shared constants and helpers for the elastic delay line and its stages.
// Defaults match the 32-bit datapath word.
package pipe_delay_line_pkg;

    localparam int          DEFAULT_WIDTH     = 32;
    localparam logic [31:0] DEFAULT_RESET_VAL = 32'h0000_0000;

    // Bits needed to hold an occupancy from 0 up to depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_delay_line_stage.sv
// One elastic stage: a data register plus its valid bit, loading from upstream
// whenever it is empty or its own content is leaving.
module pipe_stage
    import pipe_delay_line_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEFAULT_RESET_VAL)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             dn_ready,
    input  logic             flush,
    output logic             vld,
    output logic [WIDTH-1:0] data,
    output logic             rdy
);

    logic             vld_q, vld_d;
    logic [WIDTH-1:0] data_q, data_d;

    assign rdy  = !vld_q | dn_ready;
    assign vld  = vld_q;
    assign data = data_q;

    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (rdy) begin
            vld_d = up_valid;
        end
        // Bubbles and flushes never disturb the held data, only the valid bit.
        if (rdy && up_valid && !flush) begin
            data_d = up_data;
        end
        if (flush) begin
            vld_d = 1'b0;
        end
    end

    // NOTE: the data register is reset too, so out_data is a known value straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= 1'b0;
            data_q <= RESET_VAL;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/pipe_delay_line.sv
// Elastic DEPTH-stage register pipeline with valid/ready backpressure, bubble
// collapsing, synchronous flush and a registered occupancy count.
module pipe_delay_line
    import pipe_delay_line_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEFAULT_RESET_VAL)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WIDTH-1:0]              in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    input  logic                          flush,
    output logic [count_width(DEPTH)-1:0] count
);

    localparam int CW = count_width(DEPTH);

    logic [DEPTH-1:0]            vld;
    logic [DEPTH-1:0][WIDTH-1:0] data;
    logic                        head_rdy;
    logic                        in_hs;
    logic                        out_hs;
    logic [CW-1:0]               count_q, count_d;

    genvar i;
    for (i = 0; i < DEPTH; i++) begin : g_stage
        logic             up_valid_w;
        logic [WIDTH-1:0] up_data_w;
        logic             dn_ready_w;
        logic             rdy_w;

        if (i == 0) begin : g_head
            assign up_valid_w = in_valid;
            assign up_data_w  = in_data;
            assign head_rdy   = rdy_w;
        end else begin : g_body
            assign up_valid_w = vld[i-1];
            assign up_data_w  = data[i-1];
        end

        // Each link of the ready chain is its own net, keeping the chain acyclic per signal.
        if (i == DEPTH - 1) begin : g_tail
            assign dn_ready_w = out_ready;
        end else begin : g_link
            assign dn_ready_w = g_stage[i+1].rdy_w;
        end

        pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .up_valid (up_valid_w),
            .up_data  (up_data_w),
            .dn_ready (dn_ready_w),
            .flush    (flush),
            .vld      (vld[i]),
            .data     (data[i]),
            .rdy      (rdy_w)
        );
    end

    assign in_ready  = head_rdy & !flush;
    assign out_valid = vld[DEPTH-1];
    assign out_data  = data[DEPTH-1];
    assign in_hs     = in_valid & in_ready;
    assign out_hs    = out_valid & out_ready;
    assign count     = count_q;

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (in_hs && !out_hs) begin
            count_d = count_q + CW'(1);
        end else if (!in_hs && out_hs) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_pipe_delay_line.sv
// Self-checking bench: four configurations of pipe_delay_line checked cycle by
// cycle against a position-based queue model of the beats in flight.
module tb_pipe_delay_line;

    typedef struct {
        logic [31:0] data;
        int          pos;
    } beat_t;

    logic clk;
    logic rst;

    logic        iv_a [4];
    logic [31:0] id_a [4];
    logic        or_a [4];
    logic        fl_a [4];

    logic        ir_a [4];
    logic        ov_a [4];
    logic [31:0] od_a [4];
    int          cnt_a [4];

    int          depth_of [4] = '{2, 4, 3, 1};
    logic [31:0] mask_of  [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_00FF};

    beat_t mq[$];
    int    checks   = 0;
    int    failures = 0;

    logic        u0_ir, u0_ov, u1_ir, u1_ov, u2_ir, u2_ov, u3_ir, u3_ov;
    logic [31:0] u0_od, u1_od, u2_od;
    logic [7:0]  u3_od;
    logic [1:0]  u0_cnt;
    logic [2:0]  u1_cnt;
    logic [1:0]  u2_cnt;
    logic [0:0]  u3_cnt;

    pipe_delay_line #(.WIDTH(32), .DEPTH(2)) u0 (
        .clk(clk), .rst(rst), .in_data(id_a[0]), .in_valid(iv_a[0]), .in_ready(u0_ir),
        .out_data(u0_od), .out_valid(u0_ov), .out_ready(or_a[0]), .flush(fl_a[0]), .count(u0_cnt));
    pipe_delay_line #(.WIDTH(32), .DEPTH(4)) u1 (
        .clk(clk), .rst(rst), .in_data(id_a[1]), .in_valid(iv_a[1]), .in_ready(u1_ir),
        .out_data(u1_od), .out_valid(u1_ov), .out_ready(or_a[1]), .flush(fl_a[1]), .count(u1_cnt));
    pipe_delay_line #(.WIDTH(32), .DEPTH(3)) u2 (
        .clk(clk), .rst(rst), .in_data(id_a[2]), .in_valid(iv_a[2]), .in_ready(u2_ir),
        .out_data(u2_od), .out_valid(u2_ov), .out_ready(or_a[2]), .flush(fl_a[2]), .count(u2_cnt));
    pipe_delay_line #(.WIDTH(8), .DEPTH(1)) u3 (
        .clk(clk), .rst(rst), .in_data(id_a[3][7:0]), .in_valid(iv_a[3]), .in_ready(u3_ir),
        .out_data(u3_od), .out_valid(u3_ov), .out_ready(or_a[3]), .flush(fl_a[3]), .count(u3_cnt));

    always_comb begin
        ir_a[0] = u0_ir; ov_a[0] = u0_ov; od_a[0] = u0_od;          cnt_a[0] = int'(u0_cnt);
        ir_a[1] = u1_ir; ov_a[1] = u1_ov; od_a[1] = u1_od;          cnt_a[1] = int'(u1_cnt);
        ir_a[2] = u2_ir; ov_a[2] = u2_ov; od_a[2] = u2_od;          cnt_a[2] = int'(u2_cnt);
        ir_a[3] = u3_ir; ov_a[3] = u3_ov; od_a[3] = {24'h0, u3_od}; cnt_a[3] = int'(u3_cnt);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock of stimulus on DUT k: compare its outputs with the model, then advance the model.
    task automatic step(input int k, input logic iv, input logic [31:0] d,
                        input logic ordy, input logic fl, input string tag);
        logic  exp_ir, exp_ov, in_hs, out_hs;
        int    limit, np;
        beat_t nb;
        @(negedge clk);
        iv_a[k] = iv; id_a[k] = d; or_a[k] = ordy; fl_a[k] = fl;
        #1;
        exp_ir = !fl && (ordy || mq.size() < depth_of[k]);
        exp_ov = (mq.size() > 0) && (mq[0].pos == depth_of[k] - 1);
        checks++;
        if (ir_a[k] !== exp_ir) begin
            failures++;
            $display("FAIL %s u%0d in_ready: got %b expected %b", tag, k, ir_a[k], exp_ir);
        end
        checks++;
        if (ov_a[k] !== exp_ov) begin
            failures++;
            $display("FAIL %s u%0d out_valid: got %b expected %b", tag, k, ov_a[k], exp_ov);
        end
        checks++;
        if (cnt_a[k] != mq.size()) begin
            failures++;
            $display("FAIL %s u%0d count: got %0d expected %0d", tag, k, cnt_a[k], mq.size());
        end
        if (exp_ov) begin
            checks++;
            if (od_a[k] !== mq[0].data) begin
                failures++;
                $display("FAIL %s u%0d out_data: got %h expected %h", tag, k, od_a[k], mq[0].data);
            end
        end
        in_hs  = iv && exp_ir;
        out_hs = exp_ov && ordy;
        if (out_hs) void'(mq.pop_front());
        // Each beat moves one stage forward unless the beat ahead of it blocks the way.
        limit = depth_of[k];
        for (int j = 0; j < mq.size(); j++) begin
            np = mq[j].pos + 1;
            if (np > limit - 1) np = limit - 1;
            mq[j].pos = np;
            limit = np;
        end
        if (fl) begin
            mq.delete();
        end else if (in_hs) begin
            nb.data = d & mask_of[k];
            nb.pos  = 0;
            mq.push_back(nb);
        end
        @(posedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            iv_a[k] = 1'b0; id_a[k] = '0; or_a[k] = 1'b0; fl_a[k] = 1'b0;
        end
        #2;
        rst = 1'b0;
        mq.delete();
    endtask

    task automatic test_reset();
        apply_reset();
        step(0, 1'b1, 32'hDEAD_0001, 1'b0, 1'b0, "reset_fill");
        step(0, 1'b1, 32'hDEAD_0002, 1'b0, 1'b0, "reset_fill");
        // Assert reset between edges: outputs must clear without waiting for a clock.
        #2;
        rst = 1'b1;
        iv_a[0] = 1'b0;
        #1;
        checks++;
        if (ov_a[0] !== 1'b0) begin
            failures++; $display("FAIL reset out_valid: got %b expected 0", ov_a[0]);
        end
        checks++;
        if (cnt_a[0] != 0) begin
            failures++; $display("FAIL reset count: got %0d expected 0", cnt_a[0]);
        end
        checks++;
        if (od_a[0] !== 32'h0000_0000) begin
            failures++; $display("FAIL reset out_data: got %h expected 00000000", od_a[0]);
        end
        checks++;
        if (ir_a[0] !== 1'b1) begin
            failures++; $display("FAIL reset in_ready: got %b expected 1", ir_a[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
    endtask

    task automatic test_streaming();
        apply_reset();
        for (int i = 1; i <= 12; i++) step(0, 1'b1, 32'(i), 1'b1, 1'b0, "stream");
        for (int i = 0; i < 3; i++) step(0, 1'b0, 32'h0, 1'b1, 1'b0, "stream_drain");
    endtask

    task automatic test_backpressure();
        logic [31:0] beats [4] = '{32'hA, 32'hB, 32'hC, 32'hD};
        apply_reset();
        for (int i = 0; i < 4; i++) step(1, 1'b1, beats[i], 1'b0, 1'b0, "bp_fill");
        @(negedge clk);
        iv_a[1] = 1'b1; or_a[1] = 1'b0;
        #1;
        checks++;
        if (cnt_a[1] != 4 || ir_a[1] !== 1'b0) begin
            failures++;
            $display("FAIL bp_full count/in_ready: got %0d/%b expected 4/0", cnt_a[1], ir_a[1]);
        end
        step(1, 1'b1, 32'hE, 1'b0, 1'b0, "bp_stall");
        for (int i = 0; i < 7; i++) step(1, 1'b0, 32'h0, 1'b1, 1'b0, "bp_drain");
    endtask

    task automatic test_full_simultaneous();
        apply_reset();
        step(0, 1'b1, 32'h11, 1'b0, 1'b0, "full_fill");
        step(0, 1'b1, 32'h22, 1'b0, 1'b0, "full_fill");
        step(0, 1'b1, 32'h55, 1'b1, 1'b0, "full_simul");
        step(0, 1'b0, 32'h0, 1'b0, 1'b0, "full_after");
        for (int i = 0; i < 3; i++) step(0, 1'b0, 32'h0, 1'b1, 1'b0, "full_drain");
    endtask

    task automatic test_flush();
        apply_reset();
        for (int i = 1; i <= 3; i++) step(2, 1'b1, 32'(i), 1'b0, 1'b0, "flush_fill");
        step(2, 1'b1, 32'hBAD, 1'b0, 1'b1, "flush_cycle");
        @(negedge clk);
        iv_a[2] = 1'b0; fl_a[2] = 1'b0;
        #1;
        checks++;
        if (cnt_a[2] != 0 || ov_a[2] !== 1'b0 || od_a[2] !== 32'h1) begin
            failures++;
            $display("FAIL flush_after count/out_valid/out_data: got %0d/%b/%h expected 0/0/00000001",
                     cnt_a[2], ov_a[2], od_a[2]);
        end
        for (int i = 0; i < 5; i++) step(2, 1'b0, 32'h0, 1'b1, 1'b0, "flush_drain");
    endtask

    task automatic test_depth1();
        apply_reset();
        for (int i = 0; i < 10; i++) step(3, 1'b1, $urandom, logic'(i % 2 == 0), 1'b0, "d1_alt");
        for (int i = 0; i < 60; i++)
            step(3, logic'($urandom_range(99) < 70), $urandom, logic'($urandom_range(99) < 50),
                 1'b0, "d1_rand");
        for (int i = 0; i < 2; i++) step(3, 1'b0, 32'h0, 1'b1, 1'b0, "d1_drain");
    endtask

    task automatic test_random(input int k);
        apply_reset();
        for (int i = 0; i < 200; i++)
            step(k, logic'($urandom_range(99) < 75), $urandom, logic'($urandom_range(99) < 60),
                 logic'($urandom_range(99) < 5), "random");
        for (int i = 0; i < depth_of[k] + 1; i++) step(k, 1'b0, 32'h0, 1'b1, 1'b0, "random_drain");
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            iv_a[k] = 1'b0; id_a[k] = '0; or_a[k] = 1'b0; fl_a[k] = 1'b0;
        end
        #12;
        rst = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_full_simultaneous();
        test_flush();
        test_depth1();
        test_random(1);
        test_random(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
